// File: rtl/game_pkg.sv
// Shared types and constants for the cat-and-mouse round controller.
// Holds state codes, direction bits, LFSR constants and the move picker.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    SCORED = 2'd2,
    OVER   = 2'd3
  } game_state_e;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] AVOID_XOR = 8'h11;

  function automatic logic [3:0] pick_dir(input logic [3:0] req);
    logic [3:0] d;
    d = '0;
    priority case (1'b1)
      req[DIR_UP]:    d[DIR_UP]    = 1'b1;
      req[DIR_DOWN]:  d[DIR_DOWN]  = 1'b1;
      req[DIR_LEFT]:  d[DIR_LEFT]  = 1'b1;
      req[DIR_RIGHT]: d[DIR_RIGHT] = 1'b1;
      default:        d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/game_sequencer_goal_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick new goal squares.
// Advances every cycle regardless of game state.
module goal_lfsr
  import game_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] value
);

  logic fb;

  assign fb = ^(value & LFSR_TAPS);

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= LFSR_SEED;
    end else begin
      value <= {value[6:0], fb};
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Round controller: paces button requests into alternating move strobes,
// detects goals and captures, and runs the round timer.
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV    = 4,
  parameter int ROUND_TICKS = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       startBtn,
  input  logic [3:0] mouseBtn,
  input  logic [3:0] catBtn,
  input  logic [3:0] CatX,
  input  logic [3:0] CatY,
  input  logic [3:0] MouseX,
  input  logic [3:0] MouseY,
  input  logic [3:0] GoalX,
  input  logic [3:0] GoalY,
  output logic [3:0] mouseMove,
  output logic [3:0] catMove,
  output logic       goalLoad,
  output logic [7:0] goalSeed,
  output logic       scoreInc,
  output logic [1:0] state,
  output logic [7:0] timeLeft,
  output logic       GameOver
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_PLAY   = PLAY;
  localparam logic [1:0] S_SCORED = SCORED;
  localparam logic [1:0] S_OVER   = OVER;

  localparam logic [7:0] LAST = 8'(TICK_DIV - 1);
  localparam logic [7:0] RT   = 8'(ROUND_TICKS);

  logic [1:0] st;
  logic [7:0] cnt;
  logic       phase;
  logic [3:0] mlat;
  logic [3:0] clat;
  logic       start_q;
  logic [7:0] lfsr_q;

  logic       start_edge;
  logic       slot_due;
  logic       hit_cat;
  logic       hit_goal;
  logic [3:0] mreq;
  logic [3:0] creq;
  logic [7:0] seed;

  goal_lfsr u_lfsr (
    .clock (clock),
    .reset (reset),
    .value (lfsr_q)
  );

  assign start_edge = startBtn & ~start_q;
  assign slot_due   = (cnt == LAST);
  assign hit_cat    = (CatX == MouseX) && (CatY == MouseY);
  assign hit_goal   = (MouseX == GoalX) && (MouseY == GoalY);
  assign mreq       = mlat | mouseBtn;
  assign creq       = clat | catBtn;
  // Never respawn the goal under the mouse.
  assign seed = (lfsr_q == {MouseX, MouseY}) ? (lfsr_q ^ AVOID_XOR)
                                             : lfsr_q;
  assign state = st;

  always_ff @(posedge clock) begin
    if (reset) begin
      st        <= S_IDLE;
      cnt       <= '0;
      phase     <= 1'b0;
      mlat      <= '0;
      clat      <= '0;
      start_q   <= 1'b0;
      mouseMove <= '0;
      catMove   <= '0;
      goalLoad  <= 1'b0;
      goalSeed  <= '0;
      scoreInc  <= 1'b0;
      timeLeft  <= RT;
      GameOver  <= 1'b0;
    end else begin
      start_q   <= startBtn;
      mouseMove <= '0;
      catMove   <= '0;
      goalLoad  <= 1'b0;
      scoreInc  <= 1'b0;
      mlat      <= mlat | mouseBtn;
      clat      <= clat | catBtn;
      if (st == S_PLAY || st == S_SCORED) begin
        cnt <= slot_due ? 8'd0 : cnt + 8'd1;
      end
      unique case (st)
        S_IDLE: begin
          if (start_edge) begin
            st       <= S_PLAY;
            timeLeft <= RT;
            cnt      <= '0;
            mlat     <= '0;
            clat     <= '0;
            phase    <= 1'b0;
          end
        end
        S_PLAY: begin
          if (hit_cat) begin
            st       <= S_OVER;
            GameOver <= 1'b1;
          end else if (hit_goal) begin
            st       <= S_SCORED;
            scoreInc <= 1'b1;
            goalLoad <= 1'b1;
            goalSeed <= seed;
          end else if (timeLeft == 8'd0) begin
            st       <= S_OVER;
            GameOver <= 1'b1;
          end else if (slot_due) begin
            phase <= ~phase;
            if (!phase) begin
              mouseMove <= pick_dir(mreq);
              mlat      <= '0;
            end else begin
              catMove  <= pick_dir(creq);
              clat     <= '0;
              timeLeft <= (timeLeft == 8'd0) ? 8'd0 : timeLeft - 8'd1;
            end
          end
        end
        S_SCORED: begin
          st <= S_PLAY;
        end
        S_OVER: begin
          if (start_edge) begin
            st       <= S_IDLE;
            GameOver <= 1'b0;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: rule-level model predicts strobes,
// a negedge monitor pops and compares them along with state and timer.
module tb_game_sequencer;

  localparam int TD = 4;
  localparam int RT = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       startBtn = 1'b0;
  logic [3:0] mouseBtn = '0;
  logic [3:0] catBtn = '0;
  logic [3:0] CatX = 4'd0, CatY = 4'd0;
  logic [3:0] MouseX = 4'd8, MouseY = 4'd8;
  logic [3:0] GoalX = 4'd15, GoalY = 4'd15;
  logic [3:0] mouseMove, catMove;
  logic       goalLoad, scoreInc, GameOver;
  logic [7:0] goalSeed, timeLeft;
  logic [1:0] state;

  always #5 clock = ~clock;

  game_sequencer #(.TICK_DIV(TD), .ROUND_TICKS(RT)) dut (
    .clock(clock), .reset(reset), .startBtn(startBtn),
    .mouseBtn(mouseBtn), .catBtn(catBtn),
    .CatX(CatX), .CatY(CatY), .MouseX(MouseX), .MouseY(MouseY),
    .GoalX(GoalX), .GoalY(GoalY),
    .mouseMove(mouseMove), .catMove(catMove),
    .goalLoad(goalLoad), .goalSeed(goalSeed), .scoreInc(scoreInc),
    .state(state), .timeLeft(timeLeft), .GameOver(GameOver)
  );

  // kind: 0 mouse step, 1 cat step, 2 score (val = forbidden seed)
  typedef struct {
    int         kind;
    logic [7:0] val;
  } rec_t;

  rec_t exq[$];
  int errors = 0;
  int checks = 0;
  int seen_mouse = 0, seen_cat = 0, seen_score = 0;

  int       m_state;
  int       m_play;
  bit       m_cat_turn;
  bit [3:0] m_mp, m_cp;
  int       m_tleft;
  bit       m_over;
  bit       m_prev_start;
  bit       m_armed = 1'b0;
  bit       m_seed_zero;

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit [3:0] first_dir(bit [3:0] r);
    for (int b = 3; b >= 0; b--)
      if (r[b]) return 4'(1 << b);
    return 4'b0;
  endfunction

  // Reference model: game rules evaluated once per clock edge.
  always @(posedge clock) begin : model
    bit [3:0] mreq, creq;
    bit       rise, due;
    rec_t     r;
    if (reset) begin
      m_state = 0; m_play = 0; m_cat_turn = 0;
      m_mp = 0; m_cp = 0; m_tleft = RT; m_over = 0;
      m_prev_start = 0; m_armed = 1; m_seed_zero = 1;
    end else begin
      rise = startBtn && !m_prev_start;
      m_prev_start = startBtn;
      mreq = m_mp | mouseBtn;
      creq = m_cp | catBtn;
      m_mp = mreq;
      m_cp = creq;
      case (m_state)
        0: if (rise) begin
          m_state = 1; m_tleft = RT; m_play = 0;
          m_mp = 0; m_cp = 0; m_cat_turn = 0;
        end
        1: begin
          due = (m_play % TD) == TD - 1;
          m_play++;
          if (CatX == MouseX && CatY == MouseY) begin
            m_state = 3; m_over = 1;
          end else if (MouseX == GoalX && MouseY == GoalY) begin
            m_state = 2; m_seed_zero = 0;
            r.kind = 2; r.val = {MouseX, MouseY};
            exq.push_back(r);
          end else if (m_tleft == 0) begin
            m_state = 3; m_over = 1;
          end else if (due) begin
            if (!m_cat_turn) begin
              if (mreq != 0) begin
                r.kind = 0; r.val = {4'b0, first_dir(mreq)};
                exq.push_back(r);
              end
              m_mp = 0;
            end else begin
              if (creq != 0) begin
                r.kind = 1; r.val = {4'b0, first_dir(creq)};
                exq.push_back(r);
              end
              m_cp = 0;
              if (m_tleft > 0) m_tleft--;
            end
            m_cat_turn = !m_cat_turn;
          end
        end
        2: begin
          m_play++;
          m_state = 1;
        end
        default: if (rise) begin
          m_state = 0; m_over = 0;
        end
      endcase
    end
  end

  always @(negedge clock) begin : monitor
    rec_t r;
    if (m_armed) begin
      if (mouseMove != 0 || catMove != 0 || scoreInc || goalLoad) begin
        if (exq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: mouse=%b cat=%b score=%b load=%b, none required",
                   mouseMove, catMove, scoreInc, goalLoad);
        end else begin
          r = exq.pop_front();
          case (r.kind)
            0: begin
              seen_mouse++;
              check("mouseMove", int'({mouseMove, catMove, scoreInc, goalLoad}),
                    int'({r.val[3:0], 4'b0, 2'b0}));
            end
            1: begin
              seen_cat++;
              check("catMove", int'({mouseMove, catMove, scoreInc, goalLoad}),
                    int'({4'b0, r.val[3:0], 2'b0}));
            end
            default: begin
              seen_score++;
              check("score_strobes", int'({mouseMove, catMove, scoreInc, goalLoad}),
                    int'({8'b0, 2'b11}));
              checks++;
              if (goalSeed == r.val) begin
                errors++;
                $display("FAIL goalSeed_avoid: got %h which equals mouse %h", goalSeed, r.val);
              end
            end
          endcase
        end
      end else if (exq.size() != 0) begin
        r = exq.pop_front();
        checks++; errors++;
        $display("FAIL missing_strobe: kind %0d value %b required, outputs all 0", r.kind, r.val);
      end
      check("state", int'(state), m_state);
      check("timeLeft", int'(timeLeft), m_tleft);
      check("GameOver", int'(GameOver), int'(m_over));
      if (m_seed_zero) check("goalSeed_reset", int'(goalSeed), 0);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic start_pulse();
    startBtn = 1'b1; cyc(1);
    startBtn = 1'b0; cyc(1);
  endtask

  task automatic to_play();
    for (int k = 0; k < 4 && m_state != 1; k++) start_pulse();
    check("reach_play", m_state, 1);
  endtask

  task automatic park();
    CatX = 0; CatY = 0; MouseX = 8; MouseY = 8; GoalX = 15; GoalY = 15;
  endtask

  initial begin
    park();
    reset = 1'b1; cyc(3);
    reset = 1'b0; cyc(2);
    // first mouse slot with a held button, no cat request
    mouseBtn = 4'b0001;
    startBtn = 1'b1; cyc(1); startBtn = 1'b0;
    cyc(3);
    mouseBtn = 4'b0000;
    cyc(2);
    // one-cycle pulse must be latched until the next mouse slot
    mouseBtn = 4'b1001; cyc(1);
    mouseBtn = 4'b0000;
    cyc(24);
    // goal hit
    to_play();
    cyc(2);
    MouseX = 5; MouseY = 5; GoalX = 5; GoalY = 5; cyc(1);
    GoalX = 15; GoalY = 15; cyc(3);
    // capture on the goal square: collision wins
    CatX = 3; CatY = 3; MouseX = 3; MouseY = 3; GoalX = 3; GoalY = 3;
    cyc(2);
    park();
    cyc(2);
    // timeout round
    to_play();
    catBtn = 4'b0110;
    cyc(30);
    catBtn = 4'b0000;
    check("timeout_over", m_state, 3);
    start_pulse();
    cyc(2);
    // reset on the edge where a slot is due
    to_play();
    mouseBtn = 4'b0100; catBtn = 4'b0010;
    for (int n = 0; n < 20 && (m_play % TD) != TD - 1; n++) cyc(1);
    check("slot_wait", m_play % TD, TD - 1);
    reset = 1'b1; cyc(1);
    reset = 1'b0; mouseBtn = 0; catBtn = 0;
    cyc(2);
    // randomized play
    for (int i = 0; i < 1500; i++) begin
      mouseBtn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      catBtn   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      if ($urandom_range(0, 5) == 0) begin
        CatX = 4'($urandom_range(0, 3)); CatY = 4'($urandom_range(0, 3));
        MouseX = 4'($urandom_range(0, 3)); MouseY = 4'($urandom_range(0, 3));
        GoalX = 4'($urandom_range(0, 3)); GoalY = 4'($urandom_range(0, 3));
      end
      startBtn = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 149) == 0);
      cyc(1);
    end
    reset = 1'b0; startBtn = 1'b0; mouseBtn = 0; catBtn = 0;
    cyc(3);
    check("queue_drained", exq.size(), 0);
    check("saw_mouse", int'(seen_mouse > 0), 1);
    check("saw_cat", int'(seen_cat > 0), 1);
    check("saw_score", int'(seen_score > 0), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
